// File: rtl/button_debounce_encoder_if.sv
// Push-button front-end bundle: raw active-low buttons in, encoded one-hot code,
// press strobe and debounced levels out.
// Ports:
//   btn_n       - raw active-low push-buttons, bit i = button i (async to clk)
//   button_code - one-hot code of the held button, 0000 when idle or locked out
//   press_pulse - one-cycle strobe when button_code leaves 0000
//   stable_btn  - debounced active-high button levels
// master: the board/test side that drives btn_n and observes the results.
// slave : the debounce/encoder block.
interface button_debounce_encoder_if;
    logic [3:0] btn_n;
    logic [3:0] button_code;
    logic       press_pulse;
    logic [3:0] stable_btn;

    modport master (
        output btn_n,
        input  button_code,
        input  press_pulse,
        input  stable_btn
    );

    modport slave (
        input  btn_n,
        output button_code,
        output press_pulse,
        output stable_btn
    );
endinterface

// File: rtl/button_debounce_encoder.sv
// Purpose: synchronise + debounce four active-low buttons and encode one held button as one-hot.
// Latency: raw edge -> stable_btn after 2+DEBOUNCE_CYCLES clk, -> button_code/press_pulse after 3+DEBOUNCE_CYCLES.
// Backpressure: none; buttons are level inputs, outputs are registered levels plus a single-cycle strobe.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - slave side of button_debounce_encoder_if (btn_n in; button_code, press_pulse, stable_btn out)
module button_debounce_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    button_debounce_encoder_if.slave      bus
);

    // Counter value on which a persisting change is accepted.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HELD    = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser. The flops hold the raw active-low level so
    // that their reset value of 1 means "released".
    // ------------------------------------------------------------------
    logic [3:0] sync1_n;
    logic [3:0] sync2_n;
    logic [3:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_n <= 4'b1111;
            sync2_n <= 4'b1111;
        end else begin
            sync1_n <= bus.btn_n;
            sync2_n <= sync1_n;
        end
    end

    assign sync2 = ~sync2_n;

    // ------------------------------------------------------------------
    // Per-button debounce. The counter only runs while the synchronised
    // level disagrees with the accepted level; any agreement (a bounce
    // back) restarts it, so a change must persist DEBOUNCE_CYCLES
    // consecutive samples. Acceptance also clears the counter, which keeps
    // it strictly below DEBOUNCE_CYCLES and therefore free of wrap.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt [4];
    logic [3:0]           stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.stable_btn = stable;

    // ------------------------------------------------------------------
    // Encoder FSM. Outputs are registered: the next-state logic also
    // produces the next button_code/press_pulse so they change on the same
    // edge as the state.
    // ------------------------------------------------------------------
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        if      (v[0]) r = 2'd0;
        else if (v[1]) r = 2'd1;
        else if (v[2]) r = 2'd2;
        else if (v[3]) r = 2'd3;
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic [3:0] code;
    logic [3:0] code_nxt;
    logic       pulse;
    logic       pulse_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= 2'd0;
            code  <= 4'b0000;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            code  <= code_nxt;
            pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        code_nxt  = 4'b0000;
        pulse_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                // Several buttons accepted together: lowest index wins.
                if (stable != 4'b0000) begin
                    idx_nxt   = lowest_set(stable);
                    state_nxt = S_HELD;
                    code_nxt  = onehot(idx_nxt);
                    pulse_nxt = 1'b1;
                end
            end

            S_HELD: begin
                // Other buttons pressed while holding are deliberately ignored.
                if (stable[idx]) begin
                    code_nxt = onehot(idx);
                end else if (stable == 4'b0000) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_LOCKOUT;
                end
            end

            S_LOCKOUT: begin
                // A fresh press needs every button released first, so a
                // leftover held button can never be reported as a new press.
                if (stable == 4'b0000) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.button_code = code;
    assign bus.press_pulse = pulse;

endmodule
